// File: rtl/wb_simple_master.sv
// Single-outstanding Wishbone B3 classic master: one valid/ready command in,
// one 8-bit read/write bus cycle out, terminated by ack, err, retry-exhaustion or timeout.
module wb_simple_master #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int MAX_RETRY      = 3
) (
  input  logic       wb_clk,
  input  logic       wb_rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_we,
  input  logic [7:0] cmd_adr,
  input  logic [7:0] cmd_dat,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_dat,
  output logic [1:0] rsp_status,
  output logic [7:0] wb_adr_o,
  output logic [7:0] wb_dat_o,
  output logic       wb_we_o,
  output logic       wb_cyc_o,
  output logic       wb_stb_o,
  output logic [2:0] wb_cti_o,
  output logic [1:0] wb_bte_o,
  input  logic [7:0] wb_dat_i,
  input  logic       wb_ack_i,
  input  logic       wb_err_i,
  input  logic       wb_rty_i
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_BUS     = 2'd1;
  localparam logic [1:0] S_BACKOFF = 2'd2;
  localparam logic [1:0] S_RESP    = 2'd3;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_ERR     = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;
  localparam logic [1:0] ST_RTY_EXH = 2'b11;

  // The last attempt cycle is the one where the counter shows TIMEOUT_CYCLES-1.
  localparam logic [7:0] TMO_LAST  = 8'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0] RETRY_MAX = 4'(MAX_RETRY);

  logic [1:0] state_q, state_d;
  logic [3:0] retry_q, retry_d;
  logic [7:0] tmo_q, tmo_d;
  logic [7:0] adr_q, adr_d;
  logic [7:0] dat_q, dat_d;
  logic       we_q, we_d;
  logic [7:0] rsp_dat_q, rsp_dat_d;
  logic [1:0] rsp_status_q, rsp_status_d;

  always_comb begin
    // NOTE: every variable gets a hold-value default first so no path leaves it unassigned (no latches).
    state_d      = state_q;
    retry_d      = retry_q;
    tmo_d        = tmo_q;
    adr_d        = adr_q;
    dat_d        = dat_q;
    we_d         = we_q;
    rsp_dat_d    = rsp_dat_q;
    rsp_status_d = rsp_status_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          state_d = S_BUS;
          we_d    = cmd_we;
          adr_d   = cmd_adr;
          dat_d   = cmd_dat;
          retry_d = 4'd0;
          tmo_d   = 8'd0;
        end
      end
      S_BUS: begin
        tmo_d = tmo_q + 8'd1;
        if (wb_ack_i) begin
          state_d      = S_RESP;
          rsp_status_d = ST_OK;
          rsp_dat_d    = we_q ? 8'h00 : wb_dat_i;
        end else if (wb_err_i) begin
          state_d      = S_RESP;
          rsp_status_d = ST_ERR;
          rsp_dat_d    = 8'h00;
        end else if (wb_rty_i) begin
          if (retry_q < RETRY_MAX) begin
            state_d = S_BACKOFF;
            retry_d = retry_q + 4'd1;
          end else begin
            state_d      = S_RESP;
            rsp_status_d = ST_RTY_EXH;
            rsp_dat_d    = 8'h00;
          end
        end else if (tmo_q == TMO_LAST) begin
          state_d      = S_RESP;
          rsp_status_d = ST_TIMEOUT;
          rsp_dat_d    = 8'h00;
        end
      end
      S_BACKOFF: begin
        state_d = S_BUS;
        tmo_d   = 8'd0;
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state updates use non-blocking assignments; the reset is synchronous, so it lives inside the clocked branch.
  always_ff @(posedge wb_clk) begin
    if (!wb_rst_n) begin
      state_q      <= S_IDLE;
      retry_q      <= 4'd0;
      tmo_q        <= 8'd0;
      adr_q        <= 8'h00;
      dat_q        <= 8'h00;
      we_q         <= 1'b0;
      rsp_dat_q    <= 8'h00;
      rsp_status_q <= ST_OK;
    end else begin
      state_q      <= state_d;
      retry_q      <= retry_d;
      tmo_q        <= tmo_d;
      adr_q        <= adr_d;
      dat_q        <= dat_d;
      we_q         <= we_d;
      rsp_dat_q    <= rsp_dat_d;
      rsp_status_q <= rsp_status_d;
    end
  end

  // cmd_ready is gated by reset so no command can be taken on a reset edge.
  assign cmd_ready  = (state_q == S_IDLE) && wb_rst_n;
  assign rsp_valid  = (state_q == S_RESP);
  assign rsp_dat    = rsp_dat_q;
  assign rsp_status = rsp_status_q;
  assign wb_cyc_o   = (state_q == S_BUS);
  assign wb_stb_o   = (state_q == S_BUS);
  assign wb_adr_o   = adr_q;
  assign wb_dat_o   = dat_q;
  assign wb_we_o    = we_q;
  assign wb_cti_o   = 3'b000;
  assign wb_bte_o   = 2'b00;

endmodule

// File: tb/tb_wb_simple_master.sv
// Self-checking bench for wb_simple_master: a scripted GPIO-style slave model and a
// scoreboard of expected responses popped at each response handshake.
module tb_wb_simple_master;

  localparam int TMO = 16;
  localparam int MR  = 3;

  logic       wb_clk = 1'b0;
  logic       wb_rst_n = 1'b0;
  logic       cmd_valid, cmd_ready, cmd_we;
  logic [7:0] cmd_adr, cmd_dat;
  logic       rsp_valid, rsp_ready;
  logic [7:0] rsp_dat;
  logic [1:0] rsp_status;
  logic [7:0] wb_adr_o, wb_dat_o, wb_dat_i;
  logic       wb_we_o, wb_cyc_o, wb_stb_o;
  logic [2:0] wb_cti_o;
  logic [1:0] wb_bte_o;
  logic       wb_ack_i, wb_err_i, wb_rty_i;

  wb_simple_master #(.TIMEOUT_CYCLES(TMO), .MAX_RETRY(MR)) dut (
    .wb_clk(wb_clk), .wb_rst_n(wb_rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_adr(cmd_adr), .cmd_dat(cmd_dat),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat), .rsp_status(rsp_status),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_we_o(wb_we_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i)
  );

  always #5 wb_clk = ~wb_clk;

  // Slave behaviour, selected per test.
  typedef enum int {M_ACK, M_ERR, M_RTY, M_NONE} mode_e;
  mode_e mode   = M_NONE;
  int    ack_at = 2;
  int    rty_n  = 0;

  int         k_cnt = 0;
  int         att   = 0;
  logic [7:0] gpio_regs [256];

  always_comb begin
    wb_ack_i = 1'b0;
    wb_err_i = 1'b0;
    wb_rty_i = 1'b0;
    wb_dat_i = 8'h5A;
    if (wb_stb_o) begin
      case (mode)
        M_ACK: wb_ack_i = (k_cnt + 1 == ack_at);
        M_ERR: wb_err_i = (k_cnt == 0);
        M_RTY: begin
          if (att < rty_n) wb_rty_i = (k_cnt == 0);
          else             wb_ack_i = (k_cnt + 1 == ack_at);
        end
        default: ;
      endcase
    end
    if (wb_ack_i && !wb_we_o) wb_dat_i = gpio_regs[wb_adr_o];
  end

  always @(posedge wb_clk) begin
    if (wb_stb_o) k_cnt <= k_cnt + 1;
    else          k_cnt <= 0;
    if (cmd_ready)                  att <= 0;
    else if (wb_stb_o && wb_rty_i)  att <= att + 1;
    if (wb_stb_o && wb_ack_i && wb_we_o) gpio_regs[wb_adr_o] <= wb_dat_o;
  end

  typedef struct {
    logic [1:0] st;
    logic [7:0] dat;
  } exp_t;
  exp_t sb_q[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Issue one command, follow the bus cycle(s), then drain the response after rsp_delay stall cycles.
  task automatic run_cmd(input string name, input logic we, input logic [7:0] adr, input logic [7:0] dat,
                         input logic [1:0] exp_st, input logic [7:0] exp_dat,
                         input int exp_stb, input int exp_bursts, input int rsp_delay);
    int         stb_n, bursts, gap, guard;
    logic       prev_stb, gap_bad, bus_bad, hold_bad, done;
    logic [7:0] d0;
    logic [1:0] s0;
    exp_t       e;
    stb_n = 0; bursts = 0; gap = 0; guard = 0;
    prev_stb = 1'b0; gap_bad = 1'b0; bus_bad = 1'b0; hold_bad = 1'b0; done = 1'b0;

    sb_q.push_back('{exp_st, exp_dat});
    cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_valid = 1'b1;
    while (!cmd_ready && guard < 50) begin
      @(negedge wb_clk);
      guard++;
    end
    check({name, ".accept"}, cmd_ready, 1);
    @(negedge wb_clk);
    cmd_valid = 1'b0;

    guard = 0;
    while (!done && guard < 300) begin
      if (rsp_valid) begin
        done = 1'b1;
      end else begin
        if (wb_stb_o) begin
          if (!prev_stb) begin
            if (bursts > 0 && gap != 1) gap_bad = 1'b1;
            bursts++;
            gap = 0;
          end
          stb_n++;
          if (wb_adr_o !== adr || wb_we_o !== we || (we && wb_dat_o !== dat) || !wb_cyc_o) bus_bad = 1'b1;
        end else if (bursts > 0) begin
          gap++;
          if (wb_cyc_o) bus_bad = 1'b1;
        end
        prev_stb = wb_stb_o;
        @(negedge wb_clk);
        guard++;
      end
    end
    e = sb_q.pop_front();
    check({name, ".rsp_seen"}, done, 1);
    check({name, ".stb_cycles"}, stb_n, exp_stb);
    check({name, ".bursts"}, bursts, exp_bursts);
    check({name, ".backoff_gap"}, gap_bad, 0);
    check({name, ".bus_stable"}, bus_bad, 0);
    check({name, ".rsp_after_stb"}, prev_stb, 1);

    s0 = rsp_status;
    d0 = rsp_dat;
    repeat (rsp_delay) begin
      if (!rsp_valid || rsp_status !== s0 || rsp_dat !== d0 || cmd_ready) hold_bad = 1'b1;
      @(negedge wb_clk);
    end
    check({name, ".rsp_hold"}, hold_bad, 0);

    rsp_ready = 1'b1;
    check({name, ".rsp_valid"}, rsp_valid, 1);
    check({name, ".status"}, rsp_status, e.st);
    check({name, ".rdat"}, rsp_dat, e.dat);
    check({name, ".cmd_ready_hs"}, cmd_ready, 0);
    @(negedge wb_clk);
    rsp_ready = 1'b0;
    check({name, ".cmd_ready_after"}, cmd_ready, 1);
    check({name, ".rsp_valid_after"}, rsp_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic bad;
    int   guard;
    cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = 8'h00; cmd_dat = 8'h00; rsp_ready = 1'b0;
    wb_rst_n = 1'b0;
    repeat (3) @(negedge wb_clk);
    check("rst.cmd_ready", cmd_ready, 0);
    check("rst.cyc", wb_cyc_o, 0);
    check("rst.stb", wb_stb_o, 0);
    check("rst.rsp_valid", rsp_valid, 0);
    check("rst.adr", wb_adr_o, 8'h00);
    check("rst.we", wb_we_o, 0);
    check("rst.cti", wb_cti_o, 3'b000);
    check("rst.bte", wb_bte_o, 2'b00);
    wb_rst_n = 1'b1;
    @(negedge wb_clk);
    check("idle.cmd_ready", cmd_ready, 1);

    // Registered-ack GPIO write to the direction register.
    mode = M_ACK; ack_at = 2;
    run_cmd("gpio_dir_wr", 1'b1, 8'h01, 8'hF0, 2'b00, 8'h00, 2, 1, 0);
    check("gpio_dir_o", gpio_regs[1], 8'hF0);

    // Zero-wait write: ack in the first stb cycle.
    ack_at = 1;
    run_cmd("zw_wr", 1'b1, 8'h00, 8'h3C, 2'b00, 8'h00, 1, 1, 0);

    // Read with response backpressure of 5 cycles.
    ack_at = 2;
    run_cmd("bp_rd", 1'b0, 8'h00, 8'hAA, 2'b00, 8'h3C, 2, 1, 5);

    // Two retries then ack.
    mode = M_RTY; rty_n = 2; ack_at = 2;
    run_cmd("rty_ok", 1'b0, 8'h01, 8'h00, 2'b00, 8'hF0, 4, 3, 0);

    // Always retry: 1 + MAX_RETRY attempts then exhausted.
    rty_n = 99;
    run_cmd("rty_exh", 1'b0, 8'h01, 8'h00, 2'b11, 8'h00, MR + 1, MR + 1, 1);

    // Error on first cycle of a read.
    mode = M_ERR;
    run_cmd("err", 1'b0, 8'h01, 8'h00, 2'b01, 8'h00, 1, 1, 0);

    // No response at all.
    mode = M_NONE;
    run_cmd("timeout", 1'b0, 8'h01, 8'h00, 2'b10, 8'h00, TMO, 1, 0);

    // Ack on the final timeout cycle wins.
    mode = M_ACK; ack_at = TMO;
    run_cmd("ack_last", 1'b0, 8'h01, 8'h00, 2'b00, 8'hF0, TMO, 1, 0);

    // Reset while a cycle is in flight.
    mode = M_NONE;
    cmd_we = 1'b0; cmd_adr = 8'h07; cmd_dat = 8'h00; cmd_valid = 1'b1;
    guard = 0;
    while (!cmd_ready && guard < 50) begin
      @(negedge wb_clk);
      guard++;
    end
    @(negedge wb_clk);
    cmd_valid = 1'b0;
    repeat (2) @(negedge wb_clk);
    check("mid.cyc_before", wb_cyc_o, 1);
    wb_rst_n = 1'b0;
    check("mid.cmd_ready_in_rst", cmd_ready, 0);
    @(negedge wb_clk);
    wb_rst_n = 1'b1;
    check("mid.cyc", wb_cyc_o, 0);
    check("mid.stb", wb_stb_o, 0);
    check("mid.rsp_valid", rsp_valid, 0);
    bad = 1'b0;
    repeat (TMO + 8) begin
      if (rsp_valid || wb_stb_o) bad = 1'b1;
      @(negedge wb_clk);
    end
    check("mid.no_rsp", bad, 0);

    mode = M_ACK; ack_at = 2;
    run_cmd("post_rst_wr", 1'b1, 8'h02, 8'h55, 2'b00, 8'h00, 2, 1, 0);
    check("post_rst_gpio", gpio_regs[2], 8'h55);
    check("sb_empty", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
